// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard scoreboard issue controller.
// Holds the register-file geometry, execution-unit and forward-select
// encodings, the per-register scoreboard entry, and small helpers.
package hazard_scoreboard_pkg;

  localparam int unsigned REG_FILE_LEN = 32;
  localparam int unsigned REG_IDX_W    = 5;
  localparam int unsigned CNT_W        = 4;
  localparam int unsigned UNIT_W       = 2;

  typedef enum logic [UNIT_W-1:0] {
    UNIT_ALU  = 2'd0,
    UNIT_LOAD = 2'd1,
    UNIT_MUL  = 2'd2
  } exec_unit_e;

  typedef enum logic [UNIT_W-1:0] {
    FWD_RF   = 2'd0,
    FWD_ALU  = 2'd1,
    FWD_LOAD = 2'd2,
    FWD_MUL  = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    logic             busy;
    logic [CNT_W-1:0] cnt;
    exec_unit_e       unit;
  } sb_entry_t;

  // Encoding 3 is illegal and behaves as ALU.
  function automatic exec_unit_e norm_unit(input logic [UNIT_W-1:0] u);
    case (u)
      2'd1:    return UNIT_LOAD;
      2'd2:    return UNIT_MUL;
      default: return UNIT_ALU;
    endcase
  endfunction

  // The counter holds L on the cycle after issue (no decrement on the load
  // edge), so the cycles still to wait before forwarding is cnt-1, floored.
  function automatic logic [CNT_W-1:0] cycles_left(input logic [CNT_W-1:0] c);
    return (c == '0) ? '0 : c - CNT_W'(1);
  endfunction

  function automatic fwd_sel_e unit_to_fwd(input exec_unit_e u);
    case (u)
      UNIT_LOAD: return FWD_LOAD;
      UNIT_MUL:  return FWD_MUL;
      default:   return FWD_ALU;
    endcase
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard entry (busy / latency counter / producing unit) for a
// single architectural register.
// Ports: clk, rst (async active-low), set_en/set_cnt/set_unit (issue of a
// writer to this register), clr_en (writeback), dec_en (pipeline advance),
// entry (registered entry state).
module hazard_scoreboard_sb_entry
  import hazard_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [CNT_W-1:0] set_cnt,
  input  exec_unit_e       set_unit,
  input  logic             clr_en,
  input  logic             dec_en,
  output sb_entry_t        entry
);

  sb_entry_t entry_q;
  sb_entry_t entry_d;

  // Decrement, then writeback clear, then issue; issue wins over both.
  always_comb begin
    entry_d = entry_q;
    if (dec_en && (entry_q.cnt != '0)) begin
      entry_d.cnt = entry_q.cnt - CNT_W'(1);
    end
    if (clr_en) begin
      entry_d.busy = 1'b0;
    end
    if (set_en) begin
      entry_d.busy = 1'b1;
      entry_d.cnt  = set_cnt;
      entry_d.unit = set_unit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry = entry_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue controller between decode and EXE. Tracks in-flight register
// writers per register, decides issue each cycle (RAW, WAW, multiplier
// occupancy), and supplies per-source forwarding selects.
// Ports: clk, rst (async active-low); dec_* decoded instruction; exe_ready
// pipeline advance; wb_valid/wb_dst writeback; issue_ready/issue_fire/
// stall_dec_out and fwd_sel_1/2 are combinational; mul_busy is registered.
// Optional macro HAZARD_STALL_CNT_EN adds the 32-bit stall_cnt output.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned ALU_LAT  = 1,
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned MUL_LAT  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec_valid,
  input  logic [REG_IDX_W-1:0] dec_src1,
  input  logic [REG_IDX_W-1:0] dec_src2,
  input  logic                 dec_use_src1,
  input  logic                 dec_use_src2,
  input  logic [REG_IDX_W-1:0] dec_dst,
  input  logic                 dec_we,
  input  logic [UNIT_W-1:0]    dec_unit,
  input  logic                 exe_ready,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_dst,
  output logic                 issue_ready,
  output logic                 issue_fire,
  output logic                 stall_dec_out,
  output logic [UNIT_W-1:0]    fwd_sel_1,
  output logic [UNIT_W-1:0]    fwd_sel_2,
  output logic                 mul_busy
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cnt
`else
  // no stall counter port in this build
`endif
);

  sb_entry_t        entries [REG_FILE_LEN];
  exec_unit_e       unit_n;
  logic [CNT_W-1:0] lat;
  logic             src1_blk;
  logic             src2_blk;
  logic             waw_blk;
  logic             mul_blk;
  logic [CNT_W-1:0] mul_cnt_q;
  logic [CNT_W-1:0] mul_cnt_d;
  logic             mul_busy_q;
  sb_entry_t        e1;
  sb_entry_t        e2;
  sb_entry_t        ed;

  // x0 is hard-wired idle.
  assign entries[0] = '0;

  for (genvar i = 1; i < REG_FILE_LEN; i++) begin : g_entry
    hazard_scoreboard_sb_entry u_entry (
      .clk      (clk),
      .rst      (rst),
      .set_en   (issue_fire && dec_we && (dec_dst == REG_IDX_W'(i))),
      .set_cnt  (lat),
      .set_unit (unit_n),
      .clr_en   (wb_valid && (wb_dst == REG_IDX_W'(i))),
      .dec_en   (exe_ready),
      .entry    (entries[i])
    );
  end

  // Hazard detection and forward selection for the decoded instruction.
  always_comb begin
    unit_n = norm_unit(dec_unit);
    case (unit_n)
      UNIT_LOAD: lat = CNT_W'(LOAD_LAT);
      UNIT_MUL:  lat = CNT_W'(MUL_LAT);
      default:   lat = CNT_W'(ALU_LAT);
    endcase

    e1 = entries[dec_src1];
    e2 = entries[dec_src2];
    ed = entries[dec_dst];

    src1_blk = dec_use_src1 && e1.busy && (cycles_left(e1.cnt) != '0);
    src2_blk = dec_use_src2 && e2.busy && (cycles_left(e2.cnt) != '0);
    // New writer must not complete before an older writer of the same rd.
    waw_blk  = dec_we && (dec_dst != '0) && ed.busy && (cycles_left(ed.cnt) >= lat);
    mul_blk  = (unit_n == UNIT_MUL) && (cycles_left(mul_cnt_q) != '0);

    issue_ready   = exe_ready && !(src1_blk || src2_blk || waw_blk || mul_blk);
    issue_fire    = dec_valid && issue_ready;
    stall_dec_out = dec_valid && !issue_ready;

    fwd_sel_1 = FWD_RF;
    if (dec_use_src1 && e1.busy && (cycles_left(e1.cnt) == '0)) begin
      fwd_sel_1 = unit_to_fwd(e1.unit);
    end
    fwd_sel_2 = FWD_RF;
    if (dec_use_src2 && e2.busy && (cycles_left(e2.cnt) == '0)) begin
      fwd_sel_2 = unit_to_fwd(e2.unit);
    end
  end

  // Non-pipelined multiplier occupancy.
  always_comb begin
    mul_cnt_d = mul_cnt_q;
    if (exe_ready && (mul_cnt_q != '0)) begin
      mul_cnt_d = mul_cnt_q - CNT_W'(1);
    end
    if (issue_fire && (unit_n == UNIT_MUL)) begin
      mul_cnt_d = CNT_W'(MUL_LAT);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_cnt_q  <= '0;
      mul_busy_q <= 1'b0;
    end else begin
      mul_cnt_q  <= mul_cnt_d;
      mul_busy_q <= (mul_cnt_d != '0);
    end
  end

  assign mul_busy = mul_busy_q;

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // Counts advancing cycles lost to a decode stall; wraps naturally.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (exe_ready && stall_dec_out) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  // stall counter not built
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: each step drives one decode
// cycle, pushes the expected outcome, and pops/compares it mid-cycle.
module tb_hazard_scoreboard;

  localparam logic [1:0] U_ALU  = 2'd0;
  localparam logic [1:0] U_LOAD = 2'd1;
  localparam logic [1:0] U_MUL  = 2'd2;
  localparam logic [1:0] U_BAD  = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       dec_valid, dec_use_src1, dec_use_src2, dec_we;
  logic [4:0] dec_src1, dec_src2, dec_dst, wb_dst;
  logic [1:0] dec_unit;
  logic       exe_ready, wb_valid;
  logic       issue_ready, issue_fire, stall_dec_out, mul_busy;
  logic [1:0] fwd_sel_1, fwd_sel_2;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  hazard_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .dec_valid     (dec_valid),
    .dec_src1      (dec_src1),
    .dec_src2      (dec_src2),
    .dec_use_src1  (dec_use_src1),
    .dec_use_src2  (dec_use_src2),
    .dec_dst       (dec_dst),
    .dec_we        (dec_we),
    .dec_unit      (dec_unit),
    .exe_ready     (exe_ready),
    .wb_valid      (wb_valid),
    .wb_dst        (wb_dst),
    .issue_ready   (issue_ready),
    .issue_fire    (issue_fire),
    .stall_dec_out (stall_dec_out),
    .fwd_sel_1     (fwd_sel_1),
    .fwd_sel_2     (fwd_sel_2),
    .mul_busy      (mul_busy)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [1:0] unit;
    logic [4:0] dst;
    logic       we;
    logic [4:0] s1;
    logic       u1;
    logic [4:0] s2;
    logic       u2;
  } ins_t;

  typedef struct {
    string      tag;
    logic       ready;
    logic       fire;
    logic       stall;
    logic [1:0] f1;
    logic [1:0] f2;
    logic       mb;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  ins_t nop      = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic ins_t mk(input logic [1:0] unit, input logic [4:0] dst,
                              input logic [4:0] s1, input logic u1,
                              input logic [4:0] s2, input logic u2);
    ins_t r;
    r.v = 1'b1; r.we = 1'b1; r.unit = unit; r.dst = dst;
    r.s1 = s1; r.u1 = u1; r.s2 = s2; r.u2 = u2;
    return r;
  endfunction

  task automatic drive(input ins_t ins, input logic er, input logic wbv, input logic [4:0] wbd);
    dec_valid = ins.v; dec_unit = ins.unit; dec_dst = ins.dst; dec_we = ins.we;
    dec_src1 = ins.s1; dec_use_src1 = ins.u1; dec_src2 = ins.s2; dec_use_src2 = ins.u2;
    exe_ready = er; wb_valid = wbv; wb_dst = wbd;
  endtask

  // One decode cycle: drive after the edge, compare at the falling edge.
  task automatic step(input string tag, input ins_t ins, input logic er,
                      input logic wbv, input logic [4:0] wbd, input logic e_ready,
                      input logic [1:0] e_f1, input logic [1:0] e_f2, input logic e_mb);
    exp_t e;
    @(posedge clk);
    #1;
    drive(ins, er, wbv, wbd);
    e.tag = tag; e.ready = e_ready; e.fire = ins.v & e_ready; e.stall = ins.v & ~e_ready;
    e.f1 = e_f1; e.f2 = e_f2; e.mb = e_mb;
    exp_q.push_back(e);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_eq("queue_underflow", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq({e.tag, ".ready"}, 32'(issue_ready), 32'(e.ready));
      check_eq({e.tag, ".fire"}, 32'(issue_fire), 32'(e.fire));
      check_eq({e.tag, ".stall"}, 32'(stall_dec_out), 32'(e.stall));
      check_eq({e.tag, ".mul_busy"}, 32'(mul_busy), 32'(e.mb));
      if (e.fire) begin
        check_eq({e.tag, ".fwd1"}, 32'(fwd_sel_1), 32'(e.f1));
        check_eq({e.tag, ".fwd2"}, 32'(fwd_sel_2), 32'(e.f2));
      end
    end
  endtask

  initial begin
    drive(nop, 1'b1, 1'b0, 5'd0);
    #12;
    check_eq("reset.ready", 32'(issue_ready), 32'd1);
    check_eq("reset.mul_busy", 32'(mul_busy), 32'd0);
    check_eq("reset.fwd1", 32'(fwd_sel_1), 32'd0);
`ifdef HAZARD_STALL_CNT_EN
    check_eq("reset.stall_cnt", stall_cnt, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // ALU back-to-back forwarding
    step("add_x5",      mk(U_ALU, 5, 0, 0, 0, 0), 1, 0, 0, 1, 0, 0, 0);
    step("add_fwd_alu", mk(U_ALU, 6, 5, 1, 0, 0), 1, 0, 0, 1, 1, 0, 0);
    // load-use: one bubble
    step("lw_x7",        mk(U_LOAD, 7, 0, 0, 0, 0), 1, 0, 0, 1, 0, 0, 0);
    step("lw_use_stall", mk(U_ALU, 11, 7, 1, 0, 0), 1, 0, 0, 0, 0, 0, 0);
    step("lw_use_fwd",   mk(U_ALU, 11, 7, 1, 0, 0), 1, 0, 0, 1, 2, 0, 0);
`ifdef HAZARD_STALL_CNT_EN
    check_eq("lw_use.stall_cnt", stall_cnt, 32'd1);
`endif
    // multiplier structural hazard
    step("mul_x8", mk(U_MUL, 8, 0, 0, 0, 0), 1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("mul_struct_stall", mk(U_MUL, 9, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0, 1);
    step("mul_issue", mk(U_MUL, 9, 0, 0, 0, 0), 1, 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) step("mul_drain", nop, 1, 0, 0, 1, 0, 0, 1);
    // WAW behind a multiply
    step("mul_x10", mk(U_MUL, 10, 0, 0, 0, 0), 1, 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) step("waw_stall", mk(U_ALU, 10, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0, 1);
    step("waw_issue", mk(U_ALU, 10, 0, 0, 0, 0), 1, 0, 0, 1, 0, 0, 1);
    // exe_ready low freezes the load counter
    step("lw_x12", mk(U_LOAD, 12, 0, 0, 0, 0), 1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("hold_exe", mk(U_ALU, 13, 12, 1, 0, 0), 0, 0, 0, 0, 0, 0, 0);
    step("hold_release_stall", mk(U_ALU, 13, 12, 1, 0, 0), 1, 0, 0, 0, 0, 0, 0);
    step("hold_release_fwd",   mk(U_ALU, 13, 12, 1, 0, 0), 1, 0, 0, 1, 2, 0, 0);
`ifdef HAZARD_STALL_CNT_EN
    check_eq("hold.stall_cnt", stall_cnt, 32'd10);
`endif
    // issue beats same-cycle writeback to the same rd
    step("wb_same_rd",      mk(U_ALU, 5, 0, 0, 0, 0), 1, 1, 5, 1, 0, 0, 0);
    step("wb_same_rd_fwd",  mk(U_ALU, 14, 5, 1, 0, 0), 1, 0, 0, 1, 1, 0, 0);
    step("wb_same_rd_lw",   mk(U_LOAD, 5, 0, 0, 0, 0), 1, 1, 5, 1, 0, 0, 0);
    step("wb_reload_stall", mk(U_ALU, 15, 5, 1, 0, 0), 1, 0, 0, 0, 0, 0, 0);
    step("wb_reload_fwd",   mk(U_ALU, 15, 5, 1, 0, 0), 1, 0, 0, 1, 2, 0, 0);
    // plain writeback clears; x0, unused sources, src2 path, illegal unit
    step("wb_clear",      nop,                        1, 1, 5, 1, 0, 0, 0);
    step("after_wb_rf",   mk(U_ALU, 16, 5, 1, 0, 0),  1, 0, 0, 1, 0, 0, 0);
    step("dst_x0",        mk(U_ALU, 0, 0, 0, 0, 0),   1, 0, 0, 1, 0, 0, 0);
    step("src_x0_nouse",  mk(U_ALU, 19, 0, 1, 7, 0),  1, 0, 0, 1, 0, 0, 0);
    step("src2_load_fwd", mk(U_ALU, 20, 0, 0, 7, 1),  1, 0, 0, 1, 0, 2, 0);
    step("unit3",         mk(U_BAD, 17, 0, 0, 0, 0),  1, 0, 0, 1, 0, 0, 0);
    step("unit3_fwd",     mk(U_ALU, 21, 17, 1, 0, 0), 1, 0, 0, 1, 1, 0, 0);
    step("lw_x22",        mk(U_LOAD, 22, 0, 0, 0, 0), 1, 0, 0, 1, 0, 0, 0);
    step("src2_stall",    mk(U_ALU, 23, 0, 0, 22, 1), 1, 0, 0, 0, 0, 0, 0);
    step("src2_fwd",      mk(U_ALU, 23, 0, 0, 22, 1), 1, 0, 0, 1, 0, 2, 0);
    // async reset in the middle of a multiply
    step("mul_x18",  mk(U_MUL, 18, 0, 0, 0, 0), 1, 0, 0, 1, 0, 0, 0);
    step("mul_live", nop,                       1, 0, 0, 1, 0, 0, 1);
    @(posedge clk);
    #2;
    drive(mk(U_ALU, 24, 18, 1, 7, 1), 1, 0, 0);
    rst = 1'b0;
    #1;
    check_eq("async_rst.mul_busy", 32'(mul_busy), 32'd0);
    check_eq("async_rst.ready", 32'(issue_ready), 32'd1);
    check_eq("async_rst.fwd1", 32'(fwd_sel_1), 32'd0);
    check_eq("async_rst.fwd2", 32'(fwd_sel_2), 32'd0);
`ifdef HAZARD_STALL_CNT_EN
    check_eq("async_rst.stall_cnt", stall_cnt, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    step("post_reset", mk(U_ALU, 25, 7, 1, 0, 0), 1, 0, 0, 1, 0, 0, 0);

    if (exp_q.size() != 0) check_eq("queue_leftover", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
